// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the streaming channel selector.
// Imported by the arbiter and the top level.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Round-robin successor of idx, wrapping at ch-1.
  function automatic int unsigned rr_next(
    input int unsigned idx,
    input int unsigned ch
  );
    return (idx == ch - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational arbiter: fixed-priority or round-robin search.
// Search starts at 0 (fixed) or at ptr (round-robin) and wraps.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int CH = 4,
  localparam int SW = $clog2(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [SW-1:0] ptr,
  input  logic          mode,
  input  logic          en,
  output logic [CH-1:0] gnt,
  output logic [SW-1:0] gnt_idx,
  output logic          any
);

  int base;
  int idx;

  // First requester in the wrapped search order wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    base    = (mode == MODE_RR) ? int'(ptr) : 0;
    if (en) begin
      for (int k = 0; k < CH; k++) begin
        idx = base + k;
        if (idx >= CH) idx = idx - CH;
        if (!any && req[idx]) begin
          any      = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = SW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// Streaming CH-to-1 selector with a one-entry output register.
// The internal arbiter picks the source; ptr tracks the last winner.
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int N  = 16,
  parameter int CH = 4,
  localparam int SW = $clog2(CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [CH-1:0] in_valid,
  input  logic [CH*N-1:0] in_data,
  output logic [CH-1:0] in_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  output logic [SW-1:0] out_sel,
  input  logic          out_ready
);

  logic [SW-1:0] ptr;
  logic          load_en;
  logic          arb_en;
  logic [CH-1:0] gnt;
  logic [SW-1:0] gnt_idx;
  logic          any;
  logic [N-1:0]  sel_data;

  assign load_en  = !out_valid || out_ready;
  assign arb_en   = load_en && !rst;
  assign in_ready = gnt;
  assign sel_data = in_data[int'(gnt_idx)*N +: N];

  rr_arbiter #(.CH(CH)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .mode    (mode),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Output register: refill on grant, drain on consume, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (any) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= gnt_idx;
      ptr       <= SW'(rr_next(int'(gnt_idx), CH));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Registered, parametrised N-bit data selector that replaces the static select-driven muxes with a CH-channel streaming selector.
- Each input channel carries a valid/ready handshake. An internal arbiter chooses the source; no external select is used.
- Output is a one-entry registered stage with valid/ready.
- Sits between multiple producers (for example, datapath units) and a single consumer bus.

Parameters:
- N, 16, data width per channel (bits); N >= 1.
- CH, 4, number of input channels; CH >= 2.
- SW, $clog2(CH), width of the channel index; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset; sampled on the clk rising edge.
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- in_valid  in  CH  per-channel valid; bit i belongs to channel i.
- in_data  in  CH*N  flattened data; channel i occupies bits [i*N +: N].
- in_ready  out  CH  per-channel ready; one-hot or zero.
- out_valid  out  1  output register holds a word.
- out_data  out  N  registered selected word.
- out_sel  out  SW  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - out_valid=0, out_data=0, out_sel=0.
  - round-robin pointer ptr=0.
- While rst=1, in_ready=0 combinationally.
- Reset mid-transfer discards the held word; no transfer completes on the reset edge.
- State is out_valid: EMPTY (0) or FULL (1).
  - load_en = !out_valid | out_ready.
- Grant (combinational):
  - If load_en=0, no grant and in_ready=0.
  - Otherwise, mode 0: g = lowest i with in_valid[i]=1.
  - Otherwise, mode 1: g = first i with in_valid[i]=1, searching ptr, ptr+1, ..., CH-1, 0, ..., ptr-1 (wrap-around modulo CH).
  - in_ready[g]=1 only when some in_valid bit is set. All other in_ready bits are 0.
  - in_ready never depends on in_valid of a non-granted channel beyond the arbiter search.
- Transfer on channel i = in_valid[i] & in_ready[i] at a clk edge. On that edge:
  - out_data <= in_data[g*N +: N].
  - out_sel <= g.
  - out_valid <= 1.
- Latency: the word appears on out_data exactly 1 cycle after the input transfer.
- Output consumed (out_valid & out_ready) with no new grant: out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous consume and load: the register refills on the same edge. This gives full throughput of 1 word/cycle and no bubble.
- FULL with out_ready=0: load_en=0, so all in_ready=0. out_data, out_sel and out_valid stay stable until accepted.
- Pointer update on a transfer from g: ptr <= (g == CH-1) ? 0 : g+1.
  - ptr also updates in mode 0, so that switching to mode 1 is fair from the last winner.
  - ptr is unchanged when no transfer occurs.
- mode may change on any cycle. It affects only the grant of that cycle and never corrupts the held word.
- No in_valid set while load_en=1: no transfer, and ptr is unchanged.
- CH not a power of 2: indices >= CH are never produced, and ptr wraps at CH-1.

Decomposition:
- Shared package stream_mux_pkg holds:
  - Mode constants MODE_FIXED=1'b0, MODE_RR=1'b1.
  - A function for the round-robin index increment modulo CH.
- One sub-module, rr_arbiter (parameter CH):
  - Inputs: req[CH], ptr[SW], mode, en.
  - Outputs: gnt one-hot[CH], gnt_idx[SW], any.
  - Purely combinational.
- The top level holds the output register, ptr, and the data select by gnt_idx.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with in_valid=4'b1111 → in_ready=0000, out_valid=0, out_data=0, out_sel=0. First grant after release goes to ch0.
- Fixed priority: mode=0, in_valid=1010, data ch1=0x1111, ch3=0x3333, out_ready=1 → ch1 is granted every cycle and out_data=0x1111 with out_sel=1 repeatedly. Ch3 gets in_ready only after in_valid[1] drops.
- Round-robin, all busy: mode=1, in_valid=1111, data ch i=0xA000+i, out_ready=1 → out_sel sequence 0,1,2,3,0 on consecutive cycles, with out_valid high every cycle.
- Backpressure: load a word 0xBEEF, then out_ready=0 for 3 cycles → in_ready=0000, and out_data=0xBEEF, out_valid=1 stay stable. Raising out_ready causes the same-edge refill with the next granted channel.
- Round-robin sparse and wrap: CH=3, mode=1, grant ch2 → ptr=0. Then in_valid=011 → ch0 is granted next, then ch1.
- Reset mid-operation: rst=1 while out_valid=1 and ptr=2 → next cycle out_valid=0 and ptr=0. The held word is never presented again.
